// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, datapath mux selects.
// The optional jump instruction is enabled with the MC_JUMP_EN macro.
package mips_ctrl_pkg;

   localparam int unsigned STATE_W = 4;
   localparam int unsigned OP_W    = 6;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9
   } state_e;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   localparam logic [1:0] SRC_B_REG     = 2'b00;
   localparam logic [1:0] SRC_B_FOUR    = 2'b01;
   localparam logic [1:0] SRC_B_IMM     = 2'b10;
   localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

endpackage

// File: rtl/mc_out_decode.sv
// Moore output decode: registered state (plus mem_ready for the fetch strobes) to datapath controls.
// JUMP outputs exist only when MC_JUMP_EN is defined; otherwise code 9 decodes as unused.
module mc_out_decode
   import mips_ctrl_pkg::*;
(
   input  state_e state_i,
   input  logic   mem_ready_i,
   output ctrl_t  ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.alu_src_b = SRC_B_FOUR;
            ctrl_o.alu_op    = ALU_OP_ADD;
            ctrl_o.pc_source = PC_SRC_ALU;
            // IR and PC capture only on the cycle the fetch completes
            ctrl_o.ir_write  = mem_ready_i;
            ctrl_o.pc_write  = mem_ready_i;
         end
         S_DECODE: begin
            ctrl_o.alu_src_b = SRC_B_IMM_SH2;
            ctrl_o.alu_op    = ALU_OP_ADD;
         end
         S_MEMADR: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRC_B_IMM;
            ctrl_o.alu_op    = ALU_OP_ADD;
         end
         S_MEMRD: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.i_or_d    = 1'b1;
         end
         S_EXEC: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRC_B_REG;
            ctrl_o.alu_op    = ALU_OP_FUNCT;
         end
         S_ALUWB: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alu_src_a     = 1'b1;
            ctrl_o.alu_src_b     = SRC_B_REG;
            ctrl_o.alu_op        = ALU_OP_SUB;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_source     = PC_SRC_ALUOUT;
         end
`ifdef MC_JUMP_EN
         S_JUMP: begin
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.pc_source = PC_SRC_JUMP;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: state register, opcode-driven sequencing, sticky illegal-opcode flag.
// Define MC_JUMP_EN to decode j (000010); otherwise it is treated as illegal.
module multicycle_control
   import mips_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OP_W-1:0]     op,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                mem_to_reg,
   output logic                reg_dst,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          alu_op,
   output logic [1:0]          pc_source,
   output logic                illegal_op,
   output logic [STATE_W-1:0]  state
);

   state_e state_q, state_d;
   logic   illegal_q, illegal_d;
   ctrl_t  ctrl_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_JUMP_EN
               OP_J:         state_d = S_JUMP;
`endif
               default: begin
                  illegal_d = 1'b1;
                  state_d   = S_FETCH;
               end
            endcase
         end
         // Only lw/sw reach address calculation, so sw is the sole store case
         S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  if (mem_ready) state_d = S_FETCH;
         S_EXEC:   state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
`ifdef MC_JUMP_EN
         S_JUMP:   state_d = S_FETCH;
`endif
         default:  state_d = S_FETCH;
      endcase
   end

   mc_out_decode u_out_decode (
      .state_i     (state_q),
      .mem_ready_i (mem_ready),
      .ctrl_o      (ctrl_c)
   );

   assign pc_write      = ctrl_c.pc_write;
   assign pc_write_cond = ctrl_c.pc_write_cond;
   assign i_or_d        = ctrl_c.i_or_d;
   assign mem_read      = ctrl_c.mem_read;
   assign mem_write     = ctrl_c.mem_write;
   assign ir_write      = ctrl_c.ir_write;
   assign mem_to_reg    = ctrl_c.mem_to_reg;
   assign reg_dst       = ctrl_c.reg_dst;
   assign reg_write     = ctrl_c.reg_write;
   assign alu_src_a     = ctrl_c.alu_src_a;
   assign alu_src_b     = ctrl_c.alu_src_b;
   assign alu_op        = ctrl_c.alu_op;
   assign pc_source     = ctrl_c.pc_source;
   assign illegal_op    = illegal_q;
   assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-length table, directed corner sequences, random instruction stream.
module tb_multicycle_control;

   logic       clk;
   logic       rst_n;
   logic [5:0] op;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic       illegal_op;
   logic [3:0] state;

   multicycle_control dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .op            (op),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .pc_source     (pc_source),
      .illegal_op    (illegal_op),
      .state         (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [5:0] T_R   = 6'b000000;
   localparam logic [5:0] T_LW  = 6'b100011;
   localparam logic [5:0] T_SW  = 6'b101011;
   localparam logic [5:0] T_BEQ = 6'b000100;
   localparam logic [5:0] T_J   = 6'b000010;
   localparam logic [5:0] T_BAD = 6'b111111;
`ifdef MC_JUMP_EN
   localparam bit JUMP_EN = 1'b1;
`else
   localparam bit JUMP_EN = 1'b0;
`endif

   int          n_vec;
   int          n_bad;
   logic        illegal_m;
   // Expected controls per state, bit order: pw pwc iod mrd mwr irw m2r rd rw asa | asb | aop | psrc
   logic [15:0] exp_tab [16];

   typedef struct {
      logic [5:0] op;
      int         len;
      logic       ill;
   } vec_t;
   vec_t tv [7];

   function automatic bit is_legal(input logic [5:0] o);
      return (o == T_R) || (o == T_LW) || (o == T_SW) || (o == T_BEQ) || (JUMP_EN && o == T_J);
   endfunction

   task automatic check_now(input int p, input logic mr, input string tag);
      logic [15:0] e;
      logic [20:0] got, want;
      e = exp_tab[p];
      if (p == 0) begin
         e[15] = mr;
         e[10] = mr;
      end
      got  = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
              mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
      want = {4'(p), e, illegal_m};
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // One clock cycle in phase p; op only matters from DECODE on, so FETCH sees junk
   task automatic cycle(input logic [5:0] o, input logic mr, input int p);
      @(negedge clk);
      op        = (p == 0) ? 6'($urandom) : o;
      mem_ready = mr;
      #1;
      check_now(p, mr, $sformatf("st%0d op%02h mr%0d", p, o, mr));
      if (p == 1 && !is_legal(o)) illegal_m = 1'b1;
   endtask

   task automatic run_instr(input logic [5:0] o, input int stall, input bit rnd);
      int ph[$];
      int k;
      ph = {0, 1};
      if (o == T_R)                    ph = {0, 1, 6, 7};
      else if (o == T_LW)              ph = {0, 1, 2, 3, 4};
      else if (o == T_SW)              ph = {0, 1, 2, 5};
      else if (o == T_BEQ)             ph = {0, 1, 8};
      else if (JUMP_EN && o == T_J)    ph = {0, 1, 9};
      foreach (ph[i]) begin
         if (ph[i] == 0 || ph[i] == 3 || ph[i] == 5) begin
            k = rnd ? int'($urandom_range(0, stall)) : stall;
            repeat (k) cycle(o, 1'b0, ph[i]);
            cycle(o, 1'b1, ph[i]);
         end else begin
            cycle(o, 1'($urandom_range(0, 1)), ph[i]);
         end
      end
   endtask

   task automatic reset_pulse(input string tag);
      @(negedge clk);
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      illegal_m = 1'b0;
      #1;
      check_now(0, 1'b0, tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      n_vec     = 0;
      n_bad     = 0;
      illegal_m = 1'b0;
      foreach (exp_tab[i]) exp_tab[i] = '0;
      exp_tab[0] = {10'b0001000000, 2'b01, 2'b00, 2'b00};
      exp_tab[1] = {10'b0000000000, 2'b11, 2'b00, 2'b00};
      exp_tab[2] = {10'b0000000001, 2'b10, 2'b00, 2'b00};
      exp_tab[3] = {10'b0011000000, 2'b00, 2'b00, 2'b00};
      exp_tab[4] = {10'b0000001010, 2'b00, 2'b00, 2'b00};
      exp_tab[5] = {10'b0010100000, 2'b00, 2'b00, 2'b00};
      exp_tab[6] = {10'b0000000001, 2'b00, 2'b10, 2'b00};
      exp_tab[7] = {10'b0000000110, 2'b00, 2'b00, 2'b00};
      exp_tab[8] = {10'b0100000001, 2'b00, 2'b01, 2'b01};
      if (JUMP_EN) exp_tab[9] = {10'b1000000000, 2'b00, 2'b00, 2'b10};

      tv[0] = '{T_R,   4, 1'b0};
      tv[1] = '{T_LW,  5, 1'b0};
      tv[2] = '{T_SW,  4, 1'b0};
      tv[3] = '{T_BEQ, 3, 1'b0};
      tv[4] = '{T_J,   JUMP_EN ? 3 : 2, !JUMP_EN};
      tv[5] = '{T_BAD, 2, 1'b1};
      tv[6] = '{T_R,   4, 1'b1};

      // Reset values with mem_ready both low and high
      rst_n     = 1'b0;
      op        = 6'd0;
      mem_ready = 1'b0;
      #1;
      check_now(0, 1'b0, "reset_mr0");
      mem_ready = 1'b1;
      #1;
      check_now(0, 1'b1, "reset_mr1");
      mem_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Instruction length and illegal flag measured from the DUT's own state trace
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         op        = tv[i].op;
         mem_ready = 1'b1;
         n = 0;
         do begin
            @(posedge clk);
            #1;
            n++;
         end while (state != 4'd0 && n < 20);
         n_vec++;
         if (n != tv[i].len) begin
            n_bad++;
            $display("FAIL len op%02h: got %0d cycles expected %0d", tv[i].op, n, tv[i].len);
         end
         n_vec++;
         if (illegal_op !== tv[i].ill) begin
            n_bad++;
            $display("FAIL illegal op%02h: got %b expected %b", tv[i].op, illegal_op, tv[i].ill);
         end
      end
      reset_pulse("reset_after_table");

      // Directed corner sequences
      run_instr(T_LW, 0, 1'b0);
      run_instr(T_R, 3, 1'b0);
      run_instr(T_BEQ, 0, 1'b0);
      run_instr(T_SW, 2, 1'b0);
      run_instr(T_J, 0, 1'b0);
      run_instr(T_BAD, 0, 1'b0);
      run_instr(T_R, 1, 1'b0);
      reset_pulse("reset_clears_illegal");

      // Asynchronous reset while stalled in MEMRD
      cycle(T_LW, 1'b1, 0);
      cycle(T_LW, 1'b1, 1);
      cycle(T_LW, 1'b1, 2);
      cycle(T_LW, 1'b0, 3);
      #2;
      rst_n     = 1'b0;
      illegal_m = 1'b0;
      #1;
      check_now(0, 1'b0, "async_rst_memrd");
      @(negedge clk);
      rst_n = 1'b1;

      // Random instruction stream with random memory stalls
      repeat (300) begin
         logic [5:0] o;
         case ($urandom_range(0, 5))
            0:       o = T_R;
            1:       o = T_LW;
            2:       o = T_SW;
            3:       o = T_BEQ;
            4:       o = T_J;
            default: o = 6'($urandom);
         endcase
         run_instr(o, 2, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
